packet_picker: RTL and testbench

- Feeds `header` and `sub` to the HDMI packet assembler, one packet per 32-pixel packet slot.
- Each slot carries one of four packet types: a user packet from a valid/ready interface, an AVI InfoFrame, an SPD InfoFrame, or a Null packet.
- Uses the assembler's 5-bit `counter` and the `data_island_period` strobe to find packet boundaries.
- Each InfoFrame is sent once per video field.

---
 rtl/packet_picker.sv | 112 +++++++++++
 tb/tb_packet_picker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_picker.sv
// Chooses which packet the HDMI data-island assembler sends in each 32-pixel slot:
// user packet, AVI InfoFrame, SPD InfoFrame or Null, with InfoFrames once per field.
module packet_picker #(
    parameter int unsigned  VIDEO_ID_CODE  = 4,
    parameter logic [1:0]   PICTURE_ASPECT = 2'b10,
    parameter logic         IT_CONTENT     = 1'b0,
    parameter logic [63:0]  VENDOR_NAME    = 64'h0,
    parameter logic [127:0] PRODUCT_DESC   = 128'h0,
    parameter logic [7:0]   SOURCE_DEVICE  = 8'h00
) (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         data_island_period,
    input  logic [4:0]   counter,
    input  logic         video_field_end,
    input  logic         user_valid,
    input  logic [23:0]  user_header,
    input  logic [223:0] user_sub,
    output logic         user_ready,
    output logic [23:0]  header,
    output logic [223:0] sub,
    output logic [1:0]   packet_type
);

    localparam logic [1:0] TypeNull = 2'd0;
    localparam logic [1:0] TypeUser = 2'd1;
    localparam logic [1:0] TypeAvi  = 2'd2;
    localparam logic [1:0] TypeSpd  = 2'd3;

    // Places PB1..PB27 (pb byte j = PB(j+1)) into subpacket layout and fills in PB0.
    // Byte 7 of each subpacket stays zero; the assembler owns it.
    function automatic logic [223:0] build_sub(input logic [23:0] hdr, input logic [215:0] pb);
        logic [223:0] s;
        logic [7:0]   sum;
        s   = '0;
        sum = hdr[7:0] + hdr[15:8] + hdr[23:16];
        for (int k = 1; k < 28; k++) begin
            s[56*(k/7) + 8*(k%7) +: 8] = pb[8*(k-1) +: 8];
            sum = sum + pb[8*(k-1) +: 8];
        end
        s[7:0] = 8'h00 - sum;
        return s;
    endfunction

    localparam logic [6:0]   VIC7       = 7'(VIDEO_ID_CODE);
    localparam logic [23:0]  AVI_HEADER = {8'd13, 8'h02, 8'h82};
    localparam logic [23:0]  SPD_HEADER = {8'd25, 8'h01, 8'h83};
    localparam logic [215:0] AVI_PB     = {184'h0, 1'b0, VIC7, IT_CONTENT, 7'b0,
                                           2'b00, PICTURE_ASPECT, 4'b1000, 8'h00};
    localparam logic [215:0] SPD_PB     = {16'h0, SOURCE_DEVICE, PRODUCT_DESC, VENDOR_NAME};
    localparam logic [223:0] AVI_SUB    = build_sub(AVI_HEADER, AVI_PB);
    localparam logic [223:0] SPD_SUB    = build_sub(SPD_HEADER, SPD_PB);

    logic         avi_pending, spd_pending;
    logic         avi_pending_d, spd_pending_d;
    logic         load, commit;
    logic [1:0]   cand_type;
    logic [23:0]  cand_header;
    logic [223:0] cand_sub;

    assign load   = !data_island_period || (counter == 5'd31);
    assign commit = data_island_period && (counter == 5'd0);

    always_comb begin
        cand_type   = TypeNull;
        cand_header = 24'h0;
        cand_sub    = '0;
        if (user_valid) begin
            cand_type   = TypeUser;
            cand_header = user_header;
            cand_sub    = user_sub;
        end else if (avi_pending) begin
            cand_type   = TypeAvi;
            cand_header = AVI_HEADER;
            cand_sub    = AVI_SUB;
        end else if (spd_pending) begin
            cand_type   = TypeSpd;
            cand_header = SPD_HEADER;
            cand_sub    = SPD_SUB;
        end
    end

    // A field-end set outranks a same-cycle commit clear.
    always_comb begin
        avi_pending_d = (avi_pending && !(commit && packet_type == TypeAvi)) || video_field_end;
        spd_pending_d = (spd_pending && !(commit && packet_type == TypeSpd)) || video_field_end;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            header      <= 24'h0;
            sub         <= '0;
            packet_type <= TypeNull;
            avi_pending <= 1'b1;
            spd_pending <= 1'b1;
        end else begin
            avi_pending <= avi_pending_d;
            spd_pending <= spd_pending_d;
            if (load) begin
                header      <= cand_header;
                sub         <= cand_sub;
                packet_type <= cand_type;
            end
        end
    end

    // Acknowledge only if the source still offers the packet being sent.
    always_comb begin
        user_ready = !reset && commit && (packet_type == TypeUser) && user_valid;
    end

endmodule

// File: tb/tb_packet_picker.sv
// Bench for packet_picker: directed slot scenarios, then randomized traffic checked
// cycle by cycle against a slot-level reference model.
module tb_packet_picker;

    localparam logic [1:0]   ASPECT = 2'b10;
    localparam logic [63:0]  VN     = 64'h4D52_4F4E_414B_4341;
    localparam logic [127:0] PD     = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0180;
    localparam logic [7:0]   SD     = 8'h09;

    logic         clk = 1'b0;
    logic         reset, dip, vfe, uv;
    logic [4:0]   counter;
    logic [23:0]  uh;
    logic [223:0] us;
    logic         user_ready;
    logic [23:0]  header;
    logic [223:0] sub;
    logic [1:0]   packet_type;

    packet_picker #(
        .VIDEO_ID_CODE (4),
        .PICTURE_ASPECT(ASPECT),
        .IT_CONTENT    (1'b0),
        .VENDOR_NAME   (VN),
        .PRODUCT_DESC  (PD),
        .SOURCE_DEVICE (SD)
    ) dut (
        .clk_pixel         (clk),
        .reset             (reset),
        .data_island_period(dip),
        .counter           (counter),
        .video_field_end   (vfe),
        .user_valid        (uv),
        .user_header       (uh),
        .user_sub          (us),
        .user_ready        (user_ready),
        .header            (header),
        .sub               (sub),
        .packet_type       (packet_type)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: which InfoFrames are owed, and the packet now on the outputs.
    logic         m_avi = 1'b1, m_spd = 1'b1;
    logic [249:0] m_pkt = '0;
    logic         last_ready = 1'b0;
    bit           rand_src = 0, auto_drop = 0;
    int           vfe_at = -1, reset_at = -1;
    logic [249:0] slot_pkts[$];
    int           ready_pos[$];
    logic [249:0] pkt16, pkt30;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet from first principles: header bytes, payload bytes, checksum, byte placement.
    function automatic logic [249:0] ref_pkt(input int t, input logic [23:0] h,
                                              input logic [223:0] s_in);
        int hb[3];
        int pb[28];
        int sum;
        logic [223:0] s;
        if (t == 0) return '0;
        if (t == 1) return {2'd1, h, s_in};
        foreach (pb[k]) pb[k] = 0;
        if (t == 2) begin
            hb = '{8'h82, 8'h02, 8'h0D};
            pb[2] = int'({2'b00, ASPECT, 4'b1000});
            pb[4] = 4;
        end else begin
            hb = '{8'h83, 8'h01, 8'h19};
            for (int k = 1; k <= 8; k++) pb[k] = int'(VN[8*(k-1) +: 8]);
            for (int k = 9; k <= 24; k++) pb[k] = int'(PD[8*(k-9) +: 8]);
            pb[25] = int'(SD);
        end
        sum = hb[0] + hb[1] + hb[2];
        for (int k = 1; k < 28; k++) sum += pb[k];
        pb[0] = (256 - (sum % 256)) % 256;
        s = '0;
        for (int k = 0; k < 28; k++) s[56*(k/7) + 8*(k%7) +: 8] = 8'(pb[k]);
        return {2'(t), 8'(hb[2]), 8'(hb[1]), 8'(hb[0]), s};
    endfunction

    function automatic int byte_sum(input logic [249:0] p);
        int s;
        s = int'(p[231:224]) + int'(p[239:232]) + int'(p[247:240]);
        for (int k = 0; k < 28; k++) s += int'(p[56*(k/7) + 8*(k%7) +: 8]);
        return s % 256;
    endfunction

    task automatic step(input int idx);
        logic         commit, load, na, ns, exp_ready;
        logic [249:0] nxt;
        #1;
        commit    = dip && (counter == 5'd0);
        load      = !dip || (counter == 5'd31);
        exp_ready = !reset && commit && (m_pkt[249:248] == 2'd1) && uv;
        chk("user_ready", {255'b0, user_ready}, {255'b0, exp_ready});
        if (dip && idx >= 0 && idx % 32 == 0) slot_pkts.push_back({packet_type, header, sub});
        if (idx == 16) pkt16 = {packet_type, header, sub};
        if (idx == 30) pkt30 = {packet_type, header, sub};
        if (user_ready && idx >= 0) ready_pos.push_back(idx);
        if (reset) begin
            nxt = '0; na = 1'b1; ns = 1'b1;
        end else begin
            na  = (m_avi && !(commit && m_pkt[249:248] == 2'd2)) || vfe;
            ns  = (m_spd && !(commit && m_pkt[249:248] == 2'd3)) || vfe;
            nxt = m_pkt;
            if (load) nxt = uv ? ref_pkt(1, uh, us) : m_avi ? ref_pkt(2, '0, '0) :
                            m_spd ? ref_pkt(3, '0, '0) : ref_pkt(0, '0, '0);
        end
        last_ready = exp_ready;
        @(posedge clk);
        #1;
        m_pkt = nxt; m_avi = na; m_spd = ns;
        chk("packet", {6'b0, packet_type, header, sub}, {6'b0, m_pkt});
        @(negedge clk);
    endtask

    task automatic source();
        if (uv && last_ready && (auto_drop || rand_src)) uv = 1'b0;
        if (rand_src) begin
            if (!uv && $urandom_range(0, 3) == 0) begin
                uv = 1'b1;
                uh = 24'($urandom);
                us = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end else if (uv && $urandom_range(0, 15) == 0) begin
                uv = 1'b0;
            end
        end
    endtask

    task automatic run_island(input int n, input int idle);
        for (int i = 0; i < idle; i++) begin
            dip = 1'b0; counter = 5'($urandom);
            vfe = rand_src && ($urandom_range(0, 40) == 0);
            reset = rand_src && ($urandom_range(0, 300) == 0);
            source();
            step(-1);
        end
        for (int i = 0; i < n * 32; i++) begin
            dip = 1'b1; counter = 5'(i % 32);
            vfe = (i == vfe_at) || (rand_src && $urandom_range(0, 40) == 0);
            reset = (i == reset_at) || (rand_src && $urandom_range(0, 300) == 0);
            source();
            step(i);
        end
        dip = 1'b0; vfe = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; dip = 1'b0; vfe = 1'b0; uv = 1'b0; counter = '0; uh = '0; us = '0;
        @(negedge clk);
        step(-1);
        chk("rst_header", {232'b0, header}, 256'h0);
        chk("rst_type", {254'b0, packet_type}, 256'h0);
        step(-1);
        reset = 1'b0;

        // 1: idle after reset shows AVI with known bytes
        run_island(0, 3);
        chk("t1_header", {232'b0, header}, 256'h0D0282);
        chk("t1_pb0_4", {216'b0, sub[39:0]}, 256'h04_00_28_00_43);
        chk("t1_type", {254'b0, packet_type}, 256'd2);

        // 2: AVI then SPD, then Null
        slot_pkts.delete(); ready_pos.delete();
        run_island(2, 2);
        run_island(1, 4);
        chk("t2_slots", slot_pkts.size(), 3);
        chk("t2_slot0", slot_pkts[0][249:248], 2);
        chk("t2_slot1", slot_pkts[1][249:248], 3);
        chk("t2_spd_hdr", slot_pkts[1][247:224], 24'h190183);
        chk("t2_spd_csum", byte_sum(slot_pkts[1]), 0);
        chk("t2_avi_csum", byte_sum(slot_pkts[0]), 0);
        chk("t2_null", slot_pkts[2], 0);
        chk("t2_ready_n", ready_pos.size(), 0);

        // 3: single user packet
        slot_pkts.delete(); ready_pos.delete();
        uv = 1'b1; uh = 24'h123456; us = {7{32'hA5C3_0F1E}}; auto_drop = 1;
        run_island(1, 3);
        auto_drop = 0;
        chk("t3_hdr0", slot_pkts[0][247:224], 24'h123456);
        chk("t3_hdr30", pkt30[247:224], 24'h123456);
        chk("t3_ready_n", ready_pos.size(), 1);
        chk("t3_ready_at", ready_pos[0], 0);

        // 4: field end coincides with AVI commit
        reset = 1'b1; step(-1); reset = 1'b0;
        slot_pkts.delete(); vfe_at = 0;
        run_island(2, 3);
        vfe_at = -1;
        run_island(1, 2);
        chk("t4_slot0", slot_pkts[0][249:248], 2);
        chk("t4_slot1", slot_pkts[1][249:248], 2);
        chk("t4_slot2", slot_pkts[2][249:248], 3);

        // 5: user valid held across three slots
        slot_pkts.delete(); ready_pos.delete();
        uv = 1'b1; uh = 24'hABCDEF;
        run_island(3, 2);
        uv = 1'b0;
        chk("t5_ready_n", ready_pos.size(), 3);
        chk("t5_ready_pos", {ready_pos[0][7:0], ready_pos[1][7:0], ready_pos[2][7:0]},
            24'h00_20_40);
        chk("t5_types", {slot_pkts[0][249:248], slot_pkts[1][249:248], slot_pkts[2][249:248]},
            6'b01_01_01);

        // 6: reset mid-AVI
        vfe = 1'b1; step(-1); vfe = 1'b0;
        slot_pkts.delete(); reset_at = 15;
        run_island(1, 3);
        reset_at = -1;
        chk("t6_slot0", slot_pkts[0][249:248], 2);
        chk("t6_after_rst", pkt16, 0);
        slot_pkts.delete();
        run_island(2, 3);
        chk("t6_next0", slot_pkts[0][249:248], 2);
        chk("t6_next1", slot_pkts[1][249:248], 3);

        // Random traffic
        rand_src = 1;
        for (int n = 0; n < 40; n++) run_island($urandom_range(1, 4), $urandom_range(1, 20));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
